// File: rtl/main_memory_responder.sv
// main_memory_responder
// Word-organised main-memory model for the memory side of the direct-mapped
// cache. A strobed single-word read or write is latched in IDLE, held for
// WAIT_STATES cycles and then committed, with a one-cycle MReady pulse.
//
// Optional build macro: MEM_RANGE_CHECK_EN
//   defined   - out-of-range or misaligned addresses are flagged on MErr,
//               writes are suppressed and reads return 32'hDEADBEEF.
//   undefined - addresses alias modulo the depth and MErr stays 0.
module main_memory_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MStrobe,
    input  logic        MRW,
    input  logic [31:0] MAddress,
    input  logic [31:0] MDataIn,
    output logic [31:0] MDataOut,
    output logic        MReady,
    output logic        MErr
);

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_STATES);
    localparam logic [31:0] ERR_WORD  = 32'hDEADBEEF;

    // Elaboration-time legality checks on the parameters.
    if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : g_bad_wait_states
        $error("main_memory_responder: WAIT_STATES must be in 0..255");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
        $error("main_memory_responder: ADDR_WIDTH must be in 1..30");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              cnt;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [31:0]             req_data;
    logic                    req_err;

    logic [31:0]             mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    in_err;

    // Signals describing the access performed on the edge entering DONE.
    logic                    commit;
    logic                    commit_rw;
    logic [ADDR_WIDTH-1:0]   commit_idx;
    logic [31:0]             commit_data;
    logic                    commit_err;

    assign in_idx = MAddress[ADDR_WIDTH+1:2];

`ifdef MEM_RANGE_CHECK_EN
    if (ADDR_WIDTH < 30) begin : g_range_hi
        assign in_err = (|MAddress[31:ADDR_WIDTH+2]) | (|MAddress[1:0]);
    end else begin : g_range_lo
        assign in_err = |MAddress[1:0];
    end
`else
    logic unused_addr_bits;
    if (ADDR_WIDTH < 30) begin : g_unused_hi
        assign unused_addr_bits = ^{MAddress[31:ADDR_WIDTH+2], MAddress[1:0]};
    end else begin : g_unused_lo
        assign unused_addr_bits = ^MAddress[1:0];
    end
    assign in_err = 1'b0;
`endif

    // Select the access that commits on this edge. With zero wait states the
    // capture edge is also the commit edge, so the live inputs are used.
    always_comb begin
        commit      = 1'b0;
        commit_rw   = req_rw;
        commit_idx  = req_idx;
        commit_data = req_data;
        commit_err  = req_err;
        case (state)
            IDLE: begin
                if (WAIT_STATES == 0 && MStrobe) begin
                    commit      = 1'b1;
                    commit_rw   = MRW;
                    commit_idx  = in_idx;
                    commit_data = MDataIn;
                    commit_err  = in_err;
                end
            end
            WAIT: begin
                if (cnt == 8'd1) begin
                    commit = 1'b1;
                end
            end
            default: begin
                commit = 1'b0;
            end
        endcase
    end

    // RAM write port; not reset, and held off while Reset is asserted so an
    // aborted write can never land.
    always_ff @(posedge clk) begin
        if (!Reset && commit && !commit_rw && !commit_err) begin
            mem[commit_idx] <= commit_data;
        end
    end

    // Request FSM with registered MReady, MErr and MDataOut.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_rw   <= 1'b0;
            req_idx  <= '0;
            req_data <= '0;
            req_err  <= 1'b0;
            MReady   <= 1'b0;
            MErr     <= 1'b0;
            MDataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    MReady <= 1'b0;
                    MErr   <= 1'b0;
                    if (MStrobe) begin
                        req_rw   <= MRW;
                        req_idx  <= in_idx;
                        req_data <= MDataIn;
                        req_err  <= in_err;
                        cnt      <= WAIT_LOAD;
                        state    <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    MReady <= 1'b0;
                    MErr   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    MReady <= 1'b0;
                    MErr   <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // The commit overrides the state-local clears above; this is how
            // the zero-wait path pulses MReady straight out of IDLE.
            if (commit) begin
                MReady <= 1'b1;
                MErr   <= commit_err;
                if (commit_rw) begin
                    MDataOut <= commit_err ? ERR_WORD : mem[commit_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

    localparam int AW    = 10;
    localparam int WS_A  = 4;
    localparam int WS_B  = 0;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst;
    logic        a_strobe, a_rw;
    logic [31:0] a_addr, a_din, a_dout;
    logic        a_ready, a_err;
    logic        b_strobe, b_rw;
    logic [31:0] b_addr, b_din, b_dout;
    logic        b_ready, b_err;

    main_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .Reset(rst), .MStrobe(a_strobe), .MRW(a_rw),
        .MAddress(a_addr), .MDataIn(a_din), .MDataOut(a_dout),
        .MReady(a_ready), .MErr(a_err)
    );

    main_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .Reset(rst), .MStrobe(b_strobe), .MRW(b_rw),
        .MAddress(b_addr), .MDataIn(b_din), .MDataOut(b_dout),
        .MReady(b_ready), .MErr(b_err)
    );

    // Reference model: plain word arrays plus the last value read out.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned when;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_a [0:DEPTH-1];
    logic [31:0] mem_b [0:DEPTH-1];
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    function automatic logic model_err(input logic [31:0] addr);
`ifdef MEM_RANGE_CHECK_EN
        return (addr >= 32'(4 * DEPTH)) || (addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void predict(input bit on_b, input logic rw,
                                    input logic [31:0] addr,
                                    input logic [31:0] data,
                                    input int unsigned when);
        int unsigned idx;
        exp_t        x;
        idx    = (addr / 4) % DEPTH;
        x.err  = model_err(addr);
        x.when = when;
        if (rw) begin
            if (x.err) x.data = 32'hDEADBEEF;
            else       x.data = on_b ? mem_b[idx] : mem_a[idx];
            if (on_b) last_b = x.data; else last_a = x.data;
        end else begin
            if (!x.err) begin
                if (on_b) mem_b[idx] = data; else mem_a[idx] = data;
            end
            x.data = on_b ? last_b : last_a;
        end
        if (on_b) qb.push_back(x); else qa.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the WAIT_STATES=4 instance.
    always @(negedge clk) begin
        if (!rst && a_ready) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_ready: got MReady=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t x;
                x = qa.pop_front();
                check("a_dataout", a_dout, x.data);
                check("a_err", 32'(a_err), 32'(x.err));
                check("a_latency", cyc, x.when);
            end
        end
    end

    // Scoreboard monitor for the zero-wait instance.
    always @(negedge clk) begin
        if (!rst && b_ready) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_ready: got MReady=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t x;
                x = qb.pop_front();
                check("b_dataout", b_dout, x.data);
                check("b_err", 32'(b_err), 32'(x.err));
                check("b_latency", cyc, x.when);
            end
        end
    end

    // One transaction on instance A; inputs are scrambled while it waits.
    task automatic issue_a(input logic rw, input logic [31:0] addr,
                           input logic [31:0] data);
        bit seen = 0;
        a_strobe = 1'b1;
        a_rw     = rw;
        a_addr   = addr;
        a_din    = data;
        predict(1'b0, rw, addr, data, cyc + 1 + WS_A);
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            if (a_ready) begin
                seen = 1;
                break;
            end
            a_strobe = 1'($urandom);
            a_rw     = 1'($urandom);
            a_addr   = {22'h0, 6'($urandom), 4'h0};
            a_din    = $urandom;
            @(negedge clk);
        end
        a_strobe = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL a_timeout: got no MReady expected one within 300 cycles");
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {20'h0, 4'h0, 6'($urandom), 2'b00};
        if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
        if ($urandom_range(0, 7) == 0) a[1:0]   = 2'($urandom);
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bw_addr [4];
        rst      = 1'b1;
        a_strobe = 1'b0; a_rw = 1'b0; a_addr = '0; a_din = '0;
        b_strobe = 1'b0; b_rw = 1'b0; b_addr = '0; b_din = '0;
        repeat (3) @(negedge clk);
        check("a_reset_ready", 32'(a_ready), 32'h0);
        check("a_reset_dout", a_dout, 32'h0);
        check("a_reset_err", 32'(a_err), 32'h0);
        check("b_reset_ready", 32'(b_ready), 32'h0);
        check("b_reset_dout", b_dout, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Preload words 0..63 and 1023 through the normal write path.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = (i == 4) ? 32'h1234_5678 : (i == 7) ? 32'h1111_1111 : $urandom;
            issue_a(1'b0, 32'(i * 4), d);
        end
        issue_a(1'b0, 32'h0000_0FFC, 32'h0BAD_0BAD);

        // Directed cases.
        issue_a(1'b1, 32'h0000_0010, 32'h0);
        issue_a(1'b0, 32'h0000_0FFC, 32'hCAFE_F00D);
        issue_a(1'b1, 32'h0000_0FFC, 32'h0);
        issue_a(1'b0, 32'h0000_1000, 32'h5A5A_A5A5);
        issue_a(1'b1, 32'h0000_0000, 32'h0);
        issue_a(1'b1, 32'h0000_0002, 32'h0);
        issue_a(1'b1, 32'h0000_0000, 32'h0);

        // Reset two cycles into a write of word 7: never completes, RAM kept.
        a_strobe = 1'b1; a_rw = 1'b0; a_addr = 32'h0000_001C; a_din = 32'hAAAA_5555;
        @(negedge clk);
        a_strobe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_dout", a_dout, 32'h0);
        check("abort_ready", 32'(a_ready), 32'h0);
        rst    = 1'b0;
        last_a = 32'h0;
        last_b = 32'h0;
        repeat (WS_A + 4) @(negedge clk);
        issue_a(1'b1, 32'h0000_001C, 32'h0);

        // Randomized traffic on instance A.
        for (int i = 0; i < 200; i++) begin
            issue_a(1'($urandom), rand_addr(), $urandom);
        end

        // Zero wait states, strobe held high: four writes then four reads.
        for (int i = 0; i < 4; i++) bw_addr[i] = {20'h0, 10'($urandom), 2'b00};
        bw_addr[3] = bw_addr[0] ^ 32'h0000_0004;
        for (int i = 0; i < 8; i++) begin
            b_strobe = 1'b1;
            b_rw     = (i >= 4);
            b_addr   = bw_addr[i % 4];
            b_din    = $urandom;
            predict(1'b1, b_rw, b_addr, b_din, cyc + 1 + WS_B);
            @(negedge clk);
            b_rw   = 1'($urandom);
            b_addr = {20'h0, 10'($urandom), 2'b00};
            b_din  = $urandom;
            @(negedge clk);
        end
        b_strobe = 1'b0;

        repeat (10) @(negedge clk);
        check("a_queue_drained", 32'(qa.size()), 32'h0);
        check("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
